// File: rtl/seq_alu_if.sv
// seq_alu operand/result bus: valid/ready handshake on both sides.
// master drives operands and out_ready; slave is the ALU.
interface seq_alu_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       cntrl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             negative;
    logic             zero;
    logic             overflow;
    logic             carry_out;

    modport master (
        output in_valid, A, B, cntrl, out_ready,
        input  in_ready, out_valid, result,
        input  negative, zero, overflow, carry_out
    );

    modport slave (
        input  in_valid, A, B, cntrl, out_ready,
        output in_ready, out_valid, result,
        output negative, zero, overflow, carry_out
    );
endinterface

// File: rtl/seq_alu.sv
// Registered multi-cycle ALU with valid/ready handshakes.
// SEQ_ALU_MUL_EN builds the iterative shift-add multiplier for op 111.
module seq_alu #(
    parameter int WIDTH = 64
) (
    input logic    clk,
    input logic    rst_n,
    seq_alu_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

`ifdef SEQ_ALU_MUL_EN
    localparam logic [2:0] OP_MUL = 3'b111;
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif

    state_t           state, next;
    logic             alive;
    logic             rdy;
    logic             load_alu;
    logic             vld_q;
    logic [WIDTH-1:0] res_q;
    logic             neg_q, zero_q, ovf_q, co_q;

    logic [WIDTH-1:0] bop;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf, alu_co;

`ifdef SEQ_ALU_MUL_EN
    logic             load_mul, mul_fin;
    logic [WIDTH-1:0] mcand, mplier, acc, acc_nxt;
    logic [SHW-1:0]   count;

    assign acc_nxt = acc + (mplier[0] ? mcand : '0);
`endif

    always_comb begin
        bop     = bus.B;
        cin     = 1'b0;
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_co  = 1'b0;
        if (bus.cntrl == 3'b011) begin
            bop = ~bus.B;
            cin = 1'b1;
        end
        sum = {1'b0, bus.A} + {1'b0, bop} + {{WIDTH{1'b0}}, cin};
        unique case (bus.cntrl)
            3'b000: alu_res = bus.B;
            3'b001: alu_res = bus.A << bus.B[SHW-1:0];
            3'b010, 3'b011: begin
                alu_res = sum[WIDTH-1:0];
                alu_co  = sum[WIDTH];
                alu_ovf = (bus.A[WIDTH-1] == bop[WIDTH-1]) &&
                          (sum[WIDTH-1] != bus.A[WIDTH-1]);
            end
            3'b100: alu_res = bus.A & bus.B;
            3'b101: alu_res = bus.A | bus.B;
            3'b110: alu_res = bus.A ^ bus.B;
            default: alu_res = bus.B;
        endcase
    end

    always_comb begin
        next     = state;
        rdy      = 1'b0;
        load_alu = 1'b0;
`ifdef SEQ_ALU_MUL_EN
        load_mul = 1'b0;
        mul_fin  = 1'b0;
`endif
        unique case (1'b1)
            (state == IDLE): rdy = alive;
`ifdef SEQ_ALU_MUL_EN
            (state == MUL): begin
                if (count == SHW'(WIDTH - 1)) begin
                    next    = DONE;
                    mul_fin = 1'b1;
                end
            end
`endif
            (state == DONE): begin
                rdy = bus.out_ready;
                if (bus.out_ready) next = IDLE;
            end
            default: next = IDLE;
        endcase
        if (bus.in_valid && rdy) begin
`ifdef SEQ_ALU_MUL_EN
            if (bus.cntrl == OP_MUL) begin
                next     = MUL;
                load_mul = 1'b1;
            end else begin
                next     = DONE;
                load_alu = 1'b1;
            end
`else
            next     = DONE;
            load_alu = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            alive  <= 1'b0;
            vld_q  <= 1'b0;
            res_q  <= '0;
            neg_q  <= 1'b0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
            co_q   <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
`endif
        end else begin
            state <= next;
            alive <= 1'b1;
            vld_q <= (next == DONE);
            if (load_alu) begin
                res_q  <= alu_res;
                neg_q  <= alu_res[WIDTH-1];
                zero_q <= (alu_res == '0);
                ovf_q  <= alu_ovf;
                co_q   <= alu_co;
            end
`ifdef SEQ_ALU_MUL_EN
            if (load_mul) begin
                mcand  <= bus.A;
                mplier <= bus.B;
                acc    <= '0;
                count  <= '0;
            end else if (state == MUL) begin
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                acc    <= acc_nxt;
                count  <= count + 1'b1;
            end
            if (mul_fin) begin
                res_q  <= acc_nxt;
                neg_q  <= acc_nxt[WIDTH-1];
                zero_q <= (acc_nxt == '0);
                ovf_q  <= 1'b0;
                co_q   <= 1'b0;
            end
`endif
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = vld_q;
    assign bus.result    = res_q;
    assign bus.negative  = neg_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = ovf_q;
    assign bus.carry_out = co_q;
endmodule

// File: tb/tb_seq_alu.sv
// Directed and random bench for seq_alu at WIDTH = 8.
// Expected values come from a plain-arithmetic model of the op table.
module tb_seq_alu;
`ifdef SEQ_ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   compared = 0;
    int   mismatched = 0;

    seq_alu_if #(.WIDTH(8)) bus ();
    seq_alu #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [11:0] obs();
        return {bus.result, bus.negative, bus.zero,
                bus.overflow, bus.carry_out};
    endfunction

    // {result, negative, zero, overflow, carry_out}
    function automatic logic [11:0] model(input logic [2:0] op,
                                          input logic [7:0] a,
                                          input logic [7:0] b);
        int ua = int'(a);
        int ub = int'(b);
        int sa = a[7] ? ua - 256 : ua;
        int sb = b[7] ? ub - 256 : ub;
        int s = 0;
        int sd = 0;
        logic [7:0] r = 8'h00;
        logic v = 1'b0;
        logic c = 1'b0;
        case (op)
            3'd0: r = b;
            3'd1: r = 8'((ua << (ub % 8)) % 256);
            3'd2: begin
                s = ua + ub;
                sd = sa + sb;
                r = 8'(s % 256);
                c = (s > 255);
                v = (sd > 127) || (sd < -128);
            end
            3'd3: begin
                s = ua + (255 - ub) + 1;
                sd = sa - sb;
                r = 8'(s % 256);
                c = (s > 255);
                v = (sd > 127) || (sd < -128);
            end
            3'd4: r = a & b;
            3'd5: r = a | b;
            3'd6: r = a ^ b;
            default: r = MUL_EN ? 8'((ua * ub) % 256) : b;
        endcase
        return {r, r[7], (r == 8'h00), v, c};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
        compared++;
        assert (o === e) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [11:0] e,
                          input string tag);
        int w = 0;
        int lat = 1;
        int lat_exp = (op == 3'b111 && MUL_EN) ? 8 : 1;
        bus.cntrl = op;
        bus.A = a;
        bus.B = b;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        while (!bus.in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        chk({tag, "_acc"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        while (!bus.out_valid && lat < 40) begin
            if (lat_exp > 1) chk({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(lat_exp));
        chk(tag, 32'(obs()), 32'(e));
    endtask

    initial begin
        logic [11:0] held;
        logic        stale;
        logic [2:0]  op;
        logic [7:0]  a, b;

        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.A = '0;
        bus.B = '0;
        bus.cntrl = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", 32'(obs()), 32'd0);
        chk("rst_vld", 32'(bus.out_valid), 32'd0);
        chk("rst_rdy", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_rdy", 32'(bus.in_ready), 32'd1);

        run_op(3'b010, 8'h7F, 8'h01, 12'h80A, "add_ovf");
        run_op(3'b011, 8'h05, 8'h05, 12'h005, "sub_zero");
        run_op(3'b001, 8'h81, 8'h03, 12'h080, "shl");
        run_op(3'b111, 8'd13, 8'd11, model(3'b111, 8'd13, 8'd11), "mul");
        run_op(3'b111, 8'h03, 8'h5A, model(3'b111, 8'h03, 8'h5A), "op7");

        // back-pressure on a pending result, then retire + accept together
        bus.cntrl = 3'b010;
        bus.A = 8'h10;
        bus.B = 8'h20;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        held = obs();
        chk("bp_res", 32'(held), 32'h300);
        repeat (3) begin
            @(posedge clk); #1;
            chk("bp_hold", 32'(obs()), 32'(held));
            chk("bp_rdy", 32'(bus.in_ready), 32'd0);
            chk("bp_vld", 32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1;
        bus.cntrl = 3'b110;
        bus.A = 8'hF0;
        bus.B = 8'hFF;
        bus.in_valid = 1'b1;
        #1;
        chk("b2b_rdy", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("b2b_xor", 32'(obs()), 32'h0F0);
        chk("b2b_vld", 32'(bus.out_valid), 32'd1);

        // reset on the 4th multiply cycle (held result when no multiplier)
        bus.cntrl = 3'b111;
        bus.A = 8'd13;
        bus.B = 8'd11;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mrst_out", 32'(obs()), 32'd0);
        chk("mrst_vld", 32'(bus.out_valid), 32'd0);
        chk("mrst_rdy", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("mrst_rel", 32'(bus.in_ready), 32'd1);
        stale = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.out_valid) stale = 1'b1;
        end
        chk("no_stale", 32'(stale), 32'd0);

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a = 8'($urandom);
            b = 8'($urandom);
            run_op(op, a, b, model(op, a, b), $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
# seq_alu

Registered, multi-cycle successor to the combinational datapath ALU. It is parametrised in `WIDTH` and keeps the existing 3-bit op encoding. It adds:
- a logical shift-left op;
- an iterative shift-add multiplier, compiled in optionally;
- valid/ready handshakes on input and output.

It sits in the execute stage. It stalls the pipeline through `in_ready` and `out_valid` whenever an op needs more than one cycle or the next stage back-pressures.

## Interface
- `WIDTH`, default 64: operand, result and flag-source width. Must be ≥ 4 and a power of two.
- `clk`  in  1  Clock, rising edge.
- `rst_n`  in  1  Reset, asynchronous, active-low.
- `in_valid`  in  1  Operands and op are valid.
- `in_ready`  out  1  Block can accept an op this cycle.
- `A`  in  WIDTH  Operand A.
- `B`  in  WIDTH  Operand B.
- `cntrl`  in  3  Op select.
- `out_valid`  out  1  `result` and flags are valid.
- `out_ready`  in  1  Consumer accepts the result.
- `result`  out  WIDTH  Registered result.
- `negative`, `zero`, `overflow`, `carry_out`  out  1 each  Registered flags.

## Operation
- Op encoding:
  - 000 pass B
  - 001 `A << B[log2(WIDTH)-1:0]`, logical
  - 010 `A + B`
  - 011 `A - B`, computed as `A + ~B + 1`
  - 100 `A & B`
  - 101 `A | B`
  - 110 `A ^ B`
  - 111 `A * B`, low WIDTH bits, unsigned
- All arithmetic is modulo 2^WIDTH.
- Flags are computed from the final result:
  - `negative` = `result[WIDTH-1]`.
  - `zero` = (`result` == 0).
  - `overflow` = signed overflow of the add/sub. It is 0 for every other op.
  - `carry_out` = carry out of the MSB of the add/sub; for sub, 1 means no borrow. It is 0 for every other op.
- States:
  - IDLE: `in_ready` = 1, `out_valid` = 0.
  - MUL: `in_ready` = 0, `out_valid` = 0.
  - DONE: `out_valid` = 1; `in_ready` = `out_ready`.
- Transitions:
  - IDLE or DONE, accepting a non-multiply op: compute in one cycle, register result and flags, go to DONE.
  - IDLE or DONE, accepting op 111: load multiplicand = A, multiplier = B, acc = 0, count = 0, go to MUL.
  - MUL, each cycle: if multiplier[0], then acc += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, count++. When count == WIDTH-1 (the last of WIDTH iterations), register the final acc and its flags and go to DONE.
  - DONE with `out_ready` = 1 and no accept: go to IDLE.
  - DONE with `out_ready` = 0: hold `result` and the flags unchanged.
- Accept happens when `in_valid` && `in_ready`. `in_valid` is ignored while `in_ready` = 0; there is no internal queue.
- Simultaneous retire and accept in DONE (`out_ready` = 1, `in_valid` = 1): the old result retires and the new op is accepted on the same edge. This gives back-to-back single-cycle throughput.
- Reset (any time, including mid-multiply):
  - State goes to IDLE.
  - `result`, all flags and `out_valid` go to 0.
  - Any in-flight op is discarded.
  - `in_ready` = 1 one cycle after `rst_n` deasserts.

## Timing
- Single-cycle ops: accepted at edge k → `out_valid` = 1 from edge k+1.
- Multiply: accepted at edge k → `out_valid` = 1 from edge k+WIDTH. Latency is fixed, with no early termination.
- `result` and flags are stable the whole time `out_valid` = 1 and `out_ready` = 0.
- `in_ready` is combinational from state and `out_ready` only. It has no path from `in_valid`, `A`, `B` or `cntrl`.
- `result`, flags and `out_valid` come directly from registers.

## Configuration
- `SEQ_ALU_MUL_EN`
  - Defined: op 111 is the iterative multiplier described above, and the MUL state and its counters exist.
  - Undefined: MUL state and multiplier logic are not built. Op 111 completes in one cycle as pass B, with `overflow` = `carry_out` = 0.

## Test plan
- WIDTH = 8, add `A` = 8'h7F, `B` = 8'h01 → one cycle after accept: `result` = 8'h80, `negative` = 1, `overflow` = 1, `carry_out` = 0, `zero` = 0.
- WIDTH = 8, sub `A` = 8'h05, `B` = 8'h05 → `result` = 8'h00, `zero` = 1, `carry_out` = 1, `overflow` = 0. Then op 001 with `A` = 8'h81, `B` = 8'h03 → `result` = 8'h08, `carry_out` = 0.
- WIDTH = 8, `SEQ_ALU_MUL_EN` defined, op 111 with `A` = 13, `B` = 11 → `out_valid` rises exactly 8 cycles after accept. `result` = 8'h8F, `negative` = 1. `in_ready` = 0 throughout MUL.
- Back-pressure: hold `out_ready` = 0 for 3 cycles with a result pending → `result` is unchanged and `in_ready` = 0. Then assert `out_ready` = 1 with `in_valid` = 1 (xor 8'hF0, 8'hFF) → the old result retires and `result` = 8'h0F on the next cycle.
- Assert `rst_n` = 0 on the 4th MUL cycle → all outputs 0 immediately. After release: `in_ready` = 1, and no stale `out_valid` ever appears.
- `SEQ_ALU_MUL_EN` undefined, op 111 with `A` = 8'h03, `B` = 8'h5A → one cycle later: `result` = 8'h5A, `overflow` = `carry_out` = 0.
